// File: rtl/lzc_stream_gen.sv
// lzc_stream_gen
// Stimulus generator for the leading-zero counter: given a requested zero
// count it emits a WORD-byte stream (MSB first) whose leading-zero count
// equals the clamped request, and exports that count for a scoreboard.
// Optional feature macro: LZC_GEN_LFSR_EN (filler bits from an 8-bit LFSR;
// when undefined all filler bits are zero and i_seed is unused).
module lzc_stream_gen #(
  parameter int WIDTH = 8,
  parameter int WORD  = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [8:0]       i_req_zeros,
  input  logic             i_req_mode,
  input  logic [7:0]       i_seed,
  input  logic             i_stall,
  output logic             o_ivalid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_mode,
  output logic [8:0]       o_exp_zeros,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [8:0] TOTAL_BITS = 9'(WORD * WIDTH);
  localparam logic [8:0] BYTE_BITS  = 9'(WIDTH);
  localparam logic [8:0] LAST_K     = 9'(WORD - 1);

  typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;

  state_t           r_state;
  logic [8:0]       r_rem;
  logic [8:0]       r_k;
  logic             r_placed;
  logic             r_last;
  logic             r_stall;

  logic [8:0]       w_clamp;
  logic             w_full;
  logic             w_placing;
  logic [8:0]       w_pos;
  logic [WIDTH-1:0] w_filler;
  logic [WIDTH-1:0] w_byte;
  logic             w_advance;

  assign w_clamp   = (i_req_zeros > TOTAL_BITS) ? TOTAL_BITS : i_req_zeros;
  assign w_full    = (r_rem >= BYTE_BITS);
  assign w_placing = !r_placed && !w_full;
  assign w_pos     = BYTE_BITS - 9'd1 - r_rem;
  assign w_advance = (r_state == SEND) && !r_stall && !r_last;

`ifdef LZC_GEN_LFSR_EN
  logic [7:0] r_lfsr;
  logic       w_lfsr_fb;

  assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  // Filler LFSR: reseeded on an accepted start, steps once per emitted byte
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lfsr <= 8'hA5;
    end else if (r_state == IDLE && i_start) begin
      r_lfsr <= (i_seed == 8'h00) ? 8'hA5 : i_seed;
    end else if (w_advance) begin
      r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
    end
  end

  // Filler bit i takes LFSR bit i, so a b-bit field uses the low b bits
  always_comb begin
    w_filler = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_filler[i] = r_lfsr[i % 8];
    end
  end
`else
  logic w_unused_seed;

  assign w_unused_seed = ^i_seed;
  assign w_filler      = '0;
`endif

  // Next byte: zeros while a full byte of zeros remains, then the marker
  // byte with the one-bit at WIDTH-1-rem, then pure filler
  always_comb begin
    w_byte = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (r_placed) begin
        w_byte[i] = w_filler[i];
      end else if (w_full) begin
        w_byte[i] = 1'b0;
      end else if (9'(i) == w_pos) begin
        w_byte[i] = 1'b1;
      end else if (9'(i) < w_pos) begin
        w_byte[i] = w_filler[i];
      end else begin
        w_byte[i] = 1'b0;
      end
    end
  end

  // Stream FSM with registered outputs; stall is registered so it acts one
  // edge after it is sampled, and is only captured while streaming
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_rem       <= '0;
      r_k         <= '0;
      r_placed    <= 1'b0;
      r_last      <= 1'b0;
      r_stall     <= 1'b0;
      o_ivalid    <= 1'b0;
      o_data      <= '0;
      o_mode      <= 1'b0;
      o_exp_zeros <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          o_ivalid <= 1'b0;
          o_done   <= 1'b0;
          r_stall  <= 1'b0;
          if (i_start) begin
            r_state     <= SEND;
            o_busy      <= 1'b1;
            o_exp_zeros <= w_clamp;
            r_rem       <= w_clamp;
            o_mode      <= i_req_mode;
            r_k         <= '0;
            r_placed    <= 1'b0;
            r_last      <= 1'b0;
          end
        end
        SEND: begin
          r_stall <= i_stall;
          if (r_stall) begin
            o_ivalid <= 1'b0;
          end else if (r_last) begin
            r_state  <= FIN;
            o_ivalid <= 1'b0;
            o_done   <= 1'b1;
          end else begin
            o_ivalid <= 1'b1;
            o_data   <= w_byte;
            r_k      <= r_k + 9'd1;
            if (w_full && !r_placed) begin
              r_rem <= r_rem - BYTE_BITS;
            end
            if (w_placing) begin
              r_placed <= 1'b1;
            end
            r_last <= (r_k == LAST_K) || (o_mode && w_placing);
          end
        end
        FIN: begin
          r_state <= IDLE;
          r_stall <= 1'b0;
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
        end
        default: begin
          r_state  <= IDLE;
          o_ivalid <= 1'b0;
          o_busy   <= 1'b0;
          o_done   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lzc_stream_gen.sv
// tb_lzc_stream_gen
// Scoreboard bench for lzc_stream_gen: expected bytes are derived bit by bit
// from the requested zero count and queued when a stream is started, then
// popped and compared as the DUT presents valid bytes.
module tb_lzc_stream_gen;

  localparam int WIDTH = 8;
  localparam int WORD  = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [8:0]       reqZeros = '0;
  logic             reqMode = 1'b0;
  logic [7:0]       seed = '0;
  logic             stall = 1'b0;
  logic             ivalid;
  logic [WIDTH-1:0] data;
  logic             mode;
  logic [8:0]       expZeros;
  logic             busy;
  logic             done;

  int               testsRun = 0;
  int               testsFailed = 0;
  int               cyc = 0;
  logic [7:0]       expQ[$];
  logic [7:0]       seen[$];
  logic [7:0]       lastByte = '0;
  int               streamBase = 0;

  lzc_stream_gen #(.WIDTH(WIDTH), .WORD(WORD)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_req_zeros (reqZeros),
    .i_req_mode  (reqMode),
    .i_seed      (seed),
    .i_stall     (stall),
    .o_ivalid    (ivalid),
    .o_data      (data),
    .o_mode      (mode),
    .o_exp_zeros (expZeros),
    .o_busy      (busy),
    .o_done      (done)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Free-running cycle count, used to measure latencies from the start edge
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] seenAt(input int idx);
    if (idx < seen.size()) return seen[idx];
    return 8'hxx;
  endfunction

  // Scoreboard monitor: every valid byte is popped against the queue, and
  // bubbles inside a stream must keep presenting the previous byte
  always @(negedge clk) begin
    if (!rst) begin
      if (ivalid) begin
        if (expQ.size() == 0) begin
          checkOutput("extraByte", 32'd1, 32'd0);
        end else begin
          checkOutput("data", data, expQ.pop_front());
        end
        seen.push_back(data);
        lastByte = data;
      end else if (busy && !done && seen.size() > streamBase) begin
        checkOutput("holdData", data, lastByte);
      end
    end
  end

  // Expected stream: global bit g is 0 below z, 1 at z, filler above
  task automatic applyStimulus(input int zeros, input logic m, input logic [7:0] sd,
                               output int n, output int z);
    logic [7:0] lf;
    logic [7:0] b;
    int         g;
    z = (zeros > WORD * WIDTH) ? WORD * WIDTH : zeros;
    if (m) n = (z == WORD * WIDTH) ? WORD : z / WIDTH + 1;
    else   n = WORD;
`ifdef LZC_GEN_LFSR_EN
    lf = (sd == 8'h00) ? 8'hA5 : sd;
`else
    lf = 8'h00;
    if (sd != 8'h00) lf = 8'h00;
`endif
    for (int k = 0; k < n; k++) begin
      for (int i = 7; i >= 0; i--) begin
        g = k * WIDTH + (7 - i);
        if (g < z)       b[i] = 1'b0;
        else if (g == z) b[i] = 1'b1;
        else             b[i] = lf[i];
      end
      expQ.push_back(b);
`ifdef LZC_GEN_LFSR_EN
      lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
`endif
    end
  endtask

  task automatic kickStart(input int zeros, input logic m, input logic [7:0] sd, output int t0);
    @(posedge clk); #1;
    start    = 1'b1;
    reqZeros = 9'(zeros);
    reqMode  = m;
    seed     = sd;
    @(posedge clk); #1;
    t0    = cyc;
    start = 1'b0;
  endtask

  task automatic runStream(input int zeros, input logic m, input logic [7:0] sd,
                           input int stallAt, input int stallLen, output int firstIdx);
    int n, z, t0, doneCyc, stalled;
    applyStimulus(zeros, m, sd, n, z);
    streamBase = seen.size();
    firstIdx   = streamBase;
    kickStart(zeros, m, sd, t0);
    checkOutput("busyAfterStart", busy, 1);
    checkOutput("expZeros", expZeros, z);
    checkOutput("modeLatched", mode, m);
    doneCyc = -1;
    stalled = 0;
    for (int i = 0; i < 200 && doneCyc < 0; i++) begin
      @(posedge clk); #1;
      if (done) doneCyc = cyc;
      if (stallLen > 0 && seen.size() - streamBase >= stallAt && stalled < stallLen) begin
        stall = 1'b1;
        stalled++;
      end else begin
        stall = 1'b0;
      end
    end
    stall = 1'b0;
    if (doneCyc < 0) begin
      checkOutput("doneTimeout", 32'd0, 32'd1);
    end else begin
      checkOutput("doneCycle", doneCyc - t0, n + 1 + stallLen);
      checkOutput("busyInFin", busy, 1);
      checkOutput("validCount", seen.size() - streamBase, n);
      checkOutput("queueEmpty", expQ.size(), 0);
      checkOutput("expZerosHeld", expZeros, z);
      @(posedge clk); #1;
      checkOutput("idleBusy", busy, 0);
      checkOutput("donePulse", done, 0);
    end
  endtask

  // Checks that reset mid-stream clears outputs and suppresses DONE
  task automatic checkOutputResetAbort();
    int n, z, t0, guard;
    logic sawDone;
    applyStimulus(40, 1'b0, 8'h00, n, z);
    streamBase = seen.size();
    kickStart(40, 1'b0, 8'h00, t0);
    guard = 0;
    while (seen.size() - streamBase < 5 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("reachByte5", (seen.size() - streamBase >= 5) ? 1 : 0, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    expQ.delete();
    checkOutput("rstIvalid", ivalid, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstExpZeros", expZeros, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstData", data, 0);
    sawDone = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      sawDone |= done;
    end
    checkOutput("noDoneAfterRst", sawDone, 0);
  endtask

  // Safety net so the bench cannot hang
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios followed by a short random sweep
  initial begin
    int idx;
    logic [7:0] exp3;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetIvalid", ivalid, 0);
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetDone", done, 0);
    checkOutput("resetExpZeros", expZeros, 0);
    checkOutput("resetMode", mode, 0);
    rst = 1'b0;

    runStream(0, 1'b0, 8'h00, 0, 0, idx);
    checkOutput("z0Byte0", seenAt(idx), 8'h80);
    runStream(19, 1'b1, 8'h00, 0, 0, idx);
    checkOutput("z19Byte2", seenAt(idx + 2), 8'h10);
    runStream(300, 1'b0, 8'h00, 0, 0, idx);
    runStream(300, 1'b1, 8'h00, 0, 0, idx);
    runStream(127, 1'b1, 8'h00, 0, 0, idx);
    runStream(120, 1'b1, 8'h00, 0, 0, idx);
    runStream(40, 1'b0, 8'h00, 6, 2, idx);

    checkOutputResetAbort();
    runStream(7, 1'b0, 8'h00, 0, 0, idx);
    checkOutput("z7Byte0", seenAt(idx), 8'h01);

`ifdef LZC_GEN_LFSR_EN
    exp3 = 8'h15;
`else
    exp3 = 8'h10;
`endif
    runStream(3, 1'b0, 8'h00, 0, 0, idx);
    checkOutput("z3Byte0", seenAt(idx), exp3);

    for (int r = 0; r < 6; r++) begin
      runStream($urandom_range(0, 140), 1'($urandom_range(0, 1)),
                8'($urandom_range(0, 255)), 0, 0, idx);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
